pe_driver: RTL and testbench
============================

# pe_driver

Controller that drives one PE through a complete 1-D convolution pass: it holds an input-activation row and a kernel row in local buffers, raises `start`, streams the activations and then the weights to the PE, waits for completion, and latches the three PE outputs behind a valid/ready result port. It sits between the global buffer / NoC write path and a single PE, one `pe_driver` per PE in the array.

## Interface
Parameters:
- `d_width`, 32, data width of iact, weight and outputs
- `iact_size`, 5, activations per pass; legal only with `iact_size - kernel_size + 1 == 3`
- `kernel_size`, 3, weights per pass
- `timeout`, 64, maximum cycles spent in any wait state before abort

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  buffer write strobe
- `wr_sel`  in  1  0 = iact buffer, 1 = weight buffer
- `wr_addr`  in  3  element index
- `wr_data`  in  d_width  element value
- `go`  in  1  launch pass (single-cycle pulse, accepted in IDLE only)
- `busy`  out  1  high from go acceptance until result handed off or abort
- `start`  out  1  to PE, held high for the whole pass
- `iact`  out  d_width  to PE
- `weight`  out  d_width  to PE
- `load_iact`  in  1  from PE, all activations captured
- `load_weight`  in  1  from PE, all weights captured
- `done`  in  1  from PE, pe_out0..2 valid
- `pe_out0`, `pe_out1`, `pe_out2`  in  d_width  PE results
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res0`, `res1`, `res2`  out  d_width  latched results
- `err`  out  1  sticky timeout flag, cleared by next accepted go

## Operation
- Buffers: `iact_size` and `kernel_size` registers. Write when `wr_en` high and state IDLE; out-of-range `wr_addr` or writes in any other state are dropped. Buffer contents survive passes; reset clears them to 0.
- FSM states: IDLE, SEND_IACT, WAIT_IACT, SEND_WGT, WAIT_WGT, WAIT_DONE, RESULT.
- IDLE: `go` → SEND_IACT; set `start`, `busy`, clear `err`, index=0, `iact`=buf[0]. `go` outside IDLE is ignored.
- SEND_IACT: each cycle `iact` = iact_buf[index], index increments; after element `iact_size-1` has been driven for one cycle → WAIT_IACT, `iact` holds last value.
- WAIT_IACT: on `load_iact` high → SEND_WGT, `weight`=wbuf[0], index=0. `load_iact` seen while still in SEND_IACT is also accepted: finish streaming, then go straight to SEND_WGT.
- SEND_WGT / WAIT_WGT: same rule with `kernel_size` and `load_weight`.
- WAIT_DONE: on `done` high capture `pe_out0..2` into `res0..2`, drop `start`, → RESULT with `res_valid`=1.
- RESULT: when `res_valid && res_ready` → IDLE, `res_valid`=0, `busy`=0. `res0..2` keep their value until the next capture.
- Timeout: a wait counter resets on every state change; if it reaches `timeout` in WAIT_IACT, WAIT_WGT or WAIT_DONE → set `err`, drop `start`, → IDLE, `busy`=0, no result.
- Simultaneous `go` and `wr_en` in IDLE: the write takes effect, and the pass streams the pre-write value for that element.

## Timing
- Reset values: `start`, `busy`, `res_valid`, `err` = 0; `iact`, `weight`, `res0..2` = 0; state IDLE.
- All outputs registered. `start` and `iact`=buf[0] rise at the edge that samples `go`. The PE captures one activation per edge on the following `iact_size` edges.
- Minimum pass, `go` edge to `res_valid`: 1 + iact_size + kernel_size + PE latency cycles. Each wait adds the handshake's latency.
- `done` is sampled as a level. It is only honoured in WAIT_DONE.
- Async reset mid-pass returns to IDLE immediately and clears `start`. A partially captured PE must itself be reset.

## Test plan
- Load iact 2,4,6,8,10 and weights 1,2,3, pulse `go`, run the PE model → `res0`=28, `res1`=40, `res2`=52, `res_valid`=1, `busy`=1 until handoff.
- Hold `res_ready`=0 for 10 cycles after `res_valid` → `res_valid` and `res0..2` stable; on `res_ready`=1 → IDLE one edge later, `busy`=0.
- Model that never asserts `load_weight` → `err`=1 exactly `timeout` cycles after entering WAIT_WGT, `start`=0, no `res_valid`; next `go` clears `err`.
- Assert `go` and buffer writes during a pass → ignored. Outputs equal the first pass; a second pass with the same data again gives 28/40/52.
- Deassert `rst_n` while in SEND_WGT → `start`, `busy`, `res_valid` = 0 asynchronously; after release, `go` with reloaded data completes normally.
- Write iact index 7 and weight index 3 → dropped; buffers unchanged; results unchanged.

Source files
------------

// File: rtl/pe_driver_if.sv
// Bundle of the buffer write port, PE streaming/handshake signals and the
// result port seen by one pe_driver.
interface pe_driver_if #(parameter int d_width = 32);
  logic               wr_en;
  logic               wr_sel;
  logic [2:0]         wr_addr;
  logic [d_width-1:0] wr_data;
  logic               go;
  logic               busy;
  logic               start;
  logic [d_width-1:0] iact;
  logic [d_width-1:0] weight;
  logic               load_iact;
  logic               load_weight;
  logic               done;
  logic [d_width-1:0] pe_out0, pe_out1, pe_out2;
  logic               res_valid;
  logic               res_ready;
  logic [d_width-1:0] res0, res1, res2;
  logic               err;

  modport master (
    input  wr_en, wr_sel, wr_addr, wr_data, go, load_iact, load_weight, done,
           pe_out0, pe_out1, pe_out2, res_ready,
    output busy, start, iact, weight, res_valid, res0, res1, res2, err
  );

  modport slave (
    output wr_en, wr_sel, wr_addr, wr_data, go, load_iact, load_weight, done,
           pe_out0, pe_out1, pe_out2, res_ready,
    input  busy, start, iact, weight, res_valid, res0, res1, res2, err
  );
endinterface

// File: rtl/pe_driver.sv
// Drives one PE through a 1-D convolution pass: streams the iact row then the
// kernel row, waits for done, and holds the three results behind valid/ready.
module pe_driver #(
  parameter int d_width     = 32,
  parameter int iact_size   = 5,
  parameter int kernel_size = 3,
  parameter int timeout     = 64
) (
  input logic          clk,
  input logic          rst_n,
  pe_driver_if.master  bus
);
  localparam int TW = $clog2(timeout + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_IACT, S_WAIT_IACT, S_SEND_WGT, S_WAIT_WGT, S_WAIT_DONE, S_RESULT
  } state_t;

  state_t r_state, w_nxt;

  logic [iact_size-1:0][d_width-1:0]   r_ibuf;
  logic [kernel_size-1:0][d_width-1:0] r_wbuf;
  logic [2:0]         r_idx, w_idx, w_ird_addr, w_wrd_addr;
  logic               r_ld_seen, w_ld_seen;
  logic [TW-1:0]      r_wcnt;
  logic               r_start, w_start, r_busy, w_busy, r_err, w_err, r_vld, w_vld;
  logic [d_width-1:0] r_iact, w_iact, r_weight, w_weight;
  logic [d_width-1:0] r_res0, r_res1, r_res2, w_res0, w_res1, w_res2;
  logic               r_ovr_vld, r_ovr_sel;
  logic [2:0]         r_ovr_addr;
  logic [d_width-1:0] r_ovr_data;
  logic [d_width-1:0] w_irdata, w_wrdata, w_old;
  logic               w_wr_ok, w_go, w_tmo, w_abort;

  assign w_go       = (r_state == S_IDLE) && bus.go;
  assign w_wr_ok    = (r_state == S_IDLE) && bus.wr_en;
  assign w_tmo      = (r_wcnt == TW'(timeout - 1));
  assign w_ird_addr = (r_state == S_SEND_IACT) ? r_idx + 3'd1 : 3'd0;
  assign w_wrd_addr = (r_state == S_SEND_WGT)  ? r_idx + 3'd1 : 3'd0;

  // A write landing on the go edge must not leak into the pass it launches:
  // the overwritten value is kept aside and substituted on read.
  always_comb begin
    w_irdata = '0;
    w_wrdata = '0;
    w_old    = '0;
    for (int i = 0; i < iact_size; i++) begin
      if (w_ird_addr == 3'(i)) w_irdata = r_ibuf[i];
      if (!bus.wr_sel && bus.wr_addr == 3'(i)) w_old = r_ibuf[i];
    end
    for (int i = 0; i < kernel_size; i++) begin
      if (w_wrd_addr == 3'(i)) w_wrdata = r_wbuf[i];
      if (bus.wr_sel && bus.wr_addr == 3'(i)) w_old = r_wbuf[i];
    end
    if (r_ovr_vld && !r_ovr_sel && r_ovr_addr == w_ird_addr) w_irdata = r_ovr_data;
    if (r_ovr_vld &&  r_ovr_sel && r_ovr_addr == w_wrd_addr) w_wrdata = r_ovr_data;
  end

  always_comb begin
    w_nxt     = r_state;
    w_idx     = r_idx;
    w_ld_seen = r_ld_seen;
    w_start   = r_start;
    w_busy    = r_busy;
    w_err     = r_err;
    w_vld     = r_vld;
    w_iact    = r_iact;
    w_weight  = r_weight;
    w_res0    = r_res0;
    w_res1    = r_res1;
    w_res2    = r_res2;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.go) begin
        w_nxt     = S_SEND_IACT;
        w_start   = 1'b1;
        w_busy    = 1'b1;
        w_err     = 1'b0;
        w_idx     = '0;
        w_ld_seen = 1'b0;
        w_iact    = w_irdata;
      end
      S_SEND_IACT: begin
        if (bus.load_iact) w_ld_seen = 1'b1;
        if (r_idx == 3'(iact_size - 1)) begin
          w_ld_seen = 1'b0;
          if (r_ld_seen || bus.load_iact) begin
            w_nxt    = S_SEND_WGT;
            w_weight = w_wrdata;
            w_idx    = '0;
          end else begin
            w_nxt = S_WAIT_IACT;
          end
        end else begin
          w_iact = w_irdata;
          w_idx  = r_idx + 3'd1;
        end
      end
      S_WAIT_IACT: begin
        if (bus.load_iact) begin
          w_nxt    = S_SEND_WGT;
          w_weight = w_wrdata;
          w_idx    = '0;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_SEND_WGT: begin
        if (bus.load_weight) w_ld_seen = 1'b1;
        if (r_idx == 3'(kernel_size - 1)) begin
          w_ld_seen = 1'b0;
          w_nxt     = (r_ld_seen || bus.load_weight) ? S_WAIT_DONE : S_WAIT_WGT;
        end else begin
          w_weight = w_wrdata;
          w_idx    = r_idx + 3'd1;
        end
      end
      S_WAIT_WGT: begin
        if (bus.load_weight) w_nxt = S_WAIT_DONE;
        else if (w_tmo)      w_abort = 1'b1;
      end
      S_WAIT_DONE: begin
        if (bus.done) begin
          w_nxt   = S_RESULT;
          w_res0  = bus.pe_out0;
          w_res1  = bus.pe_out1;
          w_res2  = bus.pe_out2;
          w_start = 1'b0;
          w_vld   = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      S_RESULT: if (bus.res_ready) begin
        w_nxt  = S_IDLE;
        w_vld  = 1'b0;
        w_busy = 1'b0;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_nxt   = S_IDLE;
      w_err   = 1'b1;
      w_start = 1'b0;
      w_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_ld_seen  <= 1'b0;
      r_wcnt     <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_vld      <= 1'b0;
      r_iact     <= '0;
      r_weight   <= '0;
      r_res0     <= '0;
      r_res1     <= '0;
      r_res2     <= '0;
      r_ibuf     <= '0;
      r_wbuf     <= '0;
      r_ovr_vld  <= 1'b0;
      r_ovr_sel  <= 1'b0;
      r_ovr_addr <= '0;
      r_ovr_data <= '0;
    end else begin
      r_idx     <= w_idx;
      r_ld_seen <= w_ld_seen;
      r_start   <= w_start;
      r_busy    <= w_busy;
      r_err     <= w_err;
      r_vld     <= w_vld;
      r_iact    <= w_iact;
      r_weight  <= w_weight;
      r_res0    <= w_res0;
      r_res1    <= w_res1;
      r_res2    <= w_res2;
      if (w_nxt != r_state)          r_wcnt <= '0;
      else if (r_wcnt != TW'(timeout)) r_wcnt <= r_wcnt + TW'(1);
      for (int i = 0; i < iact_size; i++)
        if (w_wr_ok && !bus.wr_sel && bus.wr_addr == 3'(i)) r_ibuf[i] <= bus.wr_data;
      for (int i = 0; i < kernel_size; i++)
        if (w_wr_ok && bus.wr_sel && bus.wr_addr == 3'(i)) r_wbuf[i] <= bus.wr_data;
      if (w_go) begin
        r_ovr_vld  <= w_wr_ok;
        r_ovr_sel  <= bus.wr_sel;
        r_ovr_addr <= bus.wr_addr;
        r_ovr_data <= w_old;
      end
    end
  end

  assign bus.start     = r_start;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.res_valid = r_vld;
  assign bus.iact      = r_iact;
  assign bus.weight    = r_weight;
  assign bus.res0      = r_res0;
  assign bus.res1      = r_res1;
  assign bus.res2      = r_res2;
endmodule

// File: tb/tb_pe_driver.sv
// Randomized bench for pe_driver: a bench-side PE captures the streams and
// results are compared against a convolution computed from shadow buffers.
module tb_pe_driver;
  localparam int DW = 32, IS = 5, KS = 3, TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_driver_if #(.d_width(DW)) bus();

  pe_driver #(.d_width(DW), .iact_size(IS), .kernel_size(KS), .timeout(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int checks = 0, errors = 0;
  logic [DW-1:0] mi[IS], mw[KS];   // what the buffers should hold
  logic [DW-1:0] ei[IS], ew[KS];   // what the current pass should stream

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] conv(input int j);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < KS; k++) s += ei[j+k] * ew[k];
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = 3'(addr); bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    if (!sel && addr < IS) mi[addr] = d;
    if (sel && addr < KS)  mw[addr] = d;
  endtask

  task automatic load_rand();
    for (int i = 0; i < IS; i++) wr(1'b0, i, DW'($urandom_range(0, 5000)));
    for (int i = 0; i < KS; i++) wr(1'b1, i, DW'($urandom_range(0, 5000)));
  endtask

  // mode: 0 normal, 1 early handshakes, 2 noise during pass, 3 weight timeout,
  //       4 reset in SEND_WGT, 5 write on the go edge
  task automatic pass(input int mode);
    logic [DW-1:0] ci[IS], cw[KS], p[3], nd;
    int hold;
    ei = mi; ew = mw;
    bus.go = 1'b1;
    if (mode == 5) begin
      nd = $urandom;
      bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 3'd2; bus.wr_data = nd;
      mi[2] = nd;
    end
    step();
    bus.go = 1'b0; bus.wr_en = 1'b0;
    chk("go_start", bus.start, 1);
    chk("go_busy", bus.busy, 1);
    chk("go_err_clr", bus.err, 0);
    for (int k = 0; k < IS; k++) begin
      ci[k] = bus.iact;
      bus.load_iact = (mode == 1 && k == 2);
      if (mode == 2) begin
        bus.go = 1'b1; bus.done = 1'b1; bus.wr_en = 1'b1;
        bus.wr_sel = 1'($urandom); bus.wr_addr = 3'($urandom); bus.wr_data = $urandom;
      end
      step();
    end
    bus.load_iact = 1'b0; bus.go = 1'b0; bus.done = 1'b0; bus.wr_en = 1'b0;
    for (int k = 0; k < IS; k++) chk($sformatf("iact%0d", k), ci[k], ei[k]);
    if (mode != 1) begin
      repeat ($urandom_range(0, 3)) step();
      bus.load_iact = 1'b1; step(); bus.load_iact = 1'b0;
    end
    for (int k = 0; k < KS; k++) begin
      cw[k] = bus.weight;
      bus.load_weight = (mode == 1 && k == 1);
      if (mode == 4 && k == 1) begin
        rst_n = 1'b0; #1;
        chk("rst_start", bus.start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_vld", bus.res_valid, 0);
        for (int i = 0; i < IS; i++) mi[i] = '0;
        for (int i = 0; i < KS; i++) mw[i] = '0;
        step();
        rst_n = 1'b1; bus.load_weight = 1'b0;
        return;
      end
      step();
    end
    bus.load_weight = 1'b0;
    for (int k = 0; k < KS; k++) chk($sformatf("wgt%0d", k), cw[k], ew[k]);
    if (mode == 3) begin
      for (int c = 1; c <= TO; c++) begin
        step();
        if (c == TO - 1) chk("tmo_early", bus.err, 0);
      end
      chk("tmo_err", bus.err, 1);
      chk("tmo_start", bus.start, 0);
      chk("tmo_busy", bus.busy, 0);
      chk("tmo_vld", bus.res_valid, 0);
      return;
    end
    if (mode != 1) begin
      repeat ($urandom_range(0, 3)) step();
      bus.load_weight = 1'b1; step(); bus.load_weight = 1'b0;
    end
    // bench PE: convolve what it actually captured
    for (int j = 0; j < 3; j++) begin
      p[j] = '0;
      for (int k = 0; k < KS; k++) p[j] += ci[j+k] * cw[k];
    end
    bus.pe_out0 = p[0]; bus.pe_out1 = p[1]; bus.pe_out2 = p[2];
    repeat ($urandom_range(0, 4)) step();
    bus.done = 1'b1; step(); bus.done = 1'b0;
    bus.pe_out0 = $urandom; bus.pe_out1 = $urandom; bus.pe_out2 = $urandom;
    chk("res_valid", bus.res_valid, 1);
    chk("res_start", bus.start, 0);
    chk("res_busy", bus.busy, 1);
    chk("res0", bus.res0, conv(0));
    chk("res1", bus.res1, conv(1));
    chk("res2", bus.res2, conv(2));
    hold = (mode == 0) ? 10 : $urandom_range(0, 6);
    repeat (hold) step();
    chk("hold_vld", bus.res_valid, 1);
    chk("hold_res0", bus.res0, conv(0));
    chk("hold_res2", bus.res2, conv(2));
    bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
    chk("hand_vld", bus.res_valid, 0);
    chk("hand_busy", bus.busy, 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.go = 0;
    bus.load_iact = 0; bus.load_weight = 0; bus.done = 0; bus.res_ready = 0;
    bus.pe_out0 = 0; bus.pe_out1 = 0; bus.pe_out2 = 0;
    for (int i = 0; i < IS; i++) mi[i] = '0;
    for (int i = 0; i < KS; i++) mw[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start0", bus.start, 0);
    chk("rst_busy0", bus.busy, 0);
    chk("rst_vld0", bus.res_valid, 0);
    chk("rst_err0", bus.err, 0);
    chk("rst_iact0", bus.iact, 0);
    chk("rst_res0", bus.res0, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < IS; i++) wr(1'b0, i, DW'(2 * (i + 1)));
    for (int i = 0; i < KS; i++) wr(1'b1, i, DW'(i + 1));
    pass(0);
    chk("plan_res0", bus.res0, 28);
    chk("plan_res1", bus.res1, 40);
    chk("plan_res2", bus.res2, 52);
    pass(2);
    pass(0);
    wr(1'b0, 7, 32'hdead_beef);
    wr(1'b1, 3, 32'hcafe_f00d);
    wr(1'b1, 6, 32'h1234_5678);
    pass(0);
    chk("oor_res1", bus.res1, 40);
    pass(1);
    pass(3);
    pass(0);
    pass(5);
    pass(0);
    pass(4);
    pass(0);
    load_rand();
    pass(0);
    for (int t = 0; t < 8; t++) begin
      load_rand();
      case ($urandom_range(0, 3))
        0: pass(0);
        1: pass(1);
        2: pass(2);
        default: pass(5);
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
